// File: rtl/lbp_hist.sv
// LBP histogram engine: clears 2^DATAWIDTH bins, then counts the LBP
// codes of all interior pixels with a serial read-modify-write loop.
module lbp_hist #(
  parameter int ADDRWIDTH = 12,
  parameter int DATAWIDTH = 8,
  parameter int CNTWIDTH  = 16,
  parameter int IMG_W     = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  output logic [ADDRWIDTH-1:0] lbp_addr,
  output logic                 lbp_OE,
  input  logic [DATAWIDTH-1:0] lbp_q,
  output logic [DATAWIDTH-1:0] hist_addr,
  output logic                 hist_OE,
  output logic                 hist_WEN,
  output logic [CNTWIDTH-1:0]  hist_d,
  input  logic [CNTWIDTH-1:0]  hist_q,
  output logic                 busy,
  output logic                 finish
);

  localparam int RW = $clog2(IMG_W);

  typedef enum logic [2:0] {
    IDLE, CLR, RD_L, RD_H, WR_H, DONE
  } state_t;

  state_t state, nxt;

  logic [DATAWIDTH-1:0] bin, code;
  logic [RW-1:0]        row, col;
  logic [CNTWIDTH-1:0]  inc;
  logic                 last_bin, last_col, last_row, start;

  assign last_bin = &bin;
  assign last_col = col == RW'(IMG_W - 2);
  assign last_row = row == RW'(IMG_W - 2);
  assign start    = enable && (state == IDLE || state == DONE);
  assign inc      = (&hist_q) ? hist_q : hist_q + CNTWIDTH'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin  <= '0;
      code <= '0;
      row  <= RW'(1);
      col  <= RW'(1);
    end else if (start) begin
      bin <= '0;
      row <= RW'(1);
      col <= RW'(1);
    end else begin
      if (state == CLR)  bin  <= bin + 1'b1;
      if (state == RD_H) code <= lbp_q;
      if (state == WR_H) begin
        if (last_col) begin
          col <= RW'(1);
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  always_comb begin
    nxt       = state;
    lbp_addr  = '0;
    lbp_OE    = 1'b0;
    hist_addr = '0;
    hist_OE   = 1'b0;
    hist_WEN  = 1'b0;
    hist_d    = '0;
    busy      = 1'b0;
    finish    = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable) nxt = CLR;
      end
      DONE: begin
        finish = 1'b1;
        if (enable) nxt = CLR;
      end
      CLR: begin
        busy      = 1'b1;
        hist_WEN  = 1'b1;
        hist_addr = bin;
        if (last_bin) nxt = RD_L;
      end
      RD_L: begin
        busy     = 1'b1;
        lbp_OE   = 1'b1;
        lbp_addr = ADDRWIDTH'(row) * ADDRWIDTH'(IMG_W)
                 + ADDRWIDTH'(col);
        nxt      = RD_H;
      end
      RD_H: begin
        busy      = 1'b1;
        hist_OE   = 1'b1;
        hist_addr = lbp_q;
        nxt       = WR_H;
      end
      WR_H: begin
        busy      = 1'b1;
        hist_WEN  = 1'b1;
        hist_addr = code;
        hist_d    = inc;
        nxt       = (last_col && last_row) ? DONE : RD_L;
      end
      default: nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lbp_hist.sv
// Directed bench for lbp_hist with behavioural synchronous RAM models.
`timescale 1ns/1ps
module tb_lbp_hist;

  localparam int LAT = 256 + 3 * 62 * 62;
  localparam int NPIX = 62 * 62;

  logic        clk = 0;
  logic        rst = 0;
  logic        enable = 0;
  logic [11:0] lbp_addr;
  logic        lbp_OE;
  logic [7:0]  lbp_q = 0;
  logic [7:0]  hist_addr;
  logic        hist_OE, hist_WEN;
  logic [15:0] hist_d;
  logic [15:0] hist_q = 0;
  logic        busy, finish;

  logic        use8 = 0;
  logic        en8;
  logic [11:0] lbp_addr8;
  logic        lbp_OE8;
  logic [7:0]  lbp_q8 = 0;
  logic [7:0]  hist_addr8;
  logic        hist_OE8, hist_WEN8;
  logic [7:0]  hist_d8;
  logic [7:0]  hist_q8 = 0;
  logic        busy8, finish8;

  logic [7:0]  lbp_mem [4096];
  logic [7:0]  lbp8_mem [4096];
  logic [15:0] hist_mem [256];
  logic [7:0]  hist8_mem [256];
  logic        pre = 0;

  int n_chk = 0;
  int n_fail = 0;
  int excl_err = 0;
  int idle_err = 0;
  int edge_err = 0;
  int expv [256];

  always #5 clk = ~clk;
  assign en8 = enable & use8;

  lbp_hist dut (
    .clk(clk), .rst(rst), .enable(enable),
    .lbp_addr(lbp_addr), .lbp_OE(lbp_OE), .lbp_q(lbp_q),
    .hist_addr(hist_addr), .hist_OE(hist_OE),
    .hist_WEN(hist_WEN), .hist_d(hist_d), .hist_q(hist_q),
    .busy(busy), .finish(finish)
  );

  lbp_hist #(.CNTWIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .enable(en8),
    .lbp_addr(lbp_addr8), .lbp_OE(lbp_OE8), .lbp_q(lbp_q8),
    .hist_addr(hist_addr8), .hist_OE(hist_OE8),
    .hist_WEN(hist_WEN8), .hist_d(hist_d8), .hist_q(hist_q8),
    .busy(busy8), .finish(finish8)
  );

  always @(posedge clk) begin
    if (lbp_OE) lbp_q <= lbp_mem[lbp_addr];
    if (pre) begin
      for (int i = 0; i < 256; i++) hist_mem[i] <= 16'hFFFF;
    end else if (hist_WEN) begin
      hist_mem[hist_addr] <= hist_d;
    end else if (hist_OE) begin
      hist_q <= hist_mem[hist_addr];
    end
  end

  always @(posedge clk) begin
    if (lbp_OE8) lbp_q8 <= lbp8_mem[lbp_addr8];
    if (hist_WEN8)     hist8_mem[hist_addr8] <= hist_d8;
    else if (hist_OE8) hist_q8 <= hist8_mem[hist_addr8];
  end

  // Protocol monitor: exclusive strobes, quiet outputs when idle,
  // and no LBP reads outside the interior.
  always @(negedge clk) begin
    if (int'(lbp_OE) + int'(hist_OE) + int'(hist_WEN) > 1)
      excl_err++;
    if (!busy && (lbp_OE || hist_OE || hist_WEN ||
        lbp_addr != 0 || hist_addr != 0 || hist_d != 0))
      idle_err++;
    if (lbp_OE && (lbp_addr[11:6] < 1 || lbp_addr[11:6] > 62 ||
        lbp_addr[5:0] < 1 || lbp_addr[5:0] > 62))
      edge_err++;
  end

  typedef struct {
    int pat;
    bit preload;
    bit hold;
    int spot_bin;
    int spot_val;
    int lat;
  } vec_t;

  vec_t vec [4];

  task automatic check(input string name, input int act,
                       input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fill(input int pat);
    for (int a = 0; a < 4096; a++) begin
      int r, c;
      bit inner;
      r = a / 64;
      c = a % 64;
      inner = r >= 1 && r <= 62 && c >= 1 && c <= 62;
      case (pat)
        0: lbp_mem[a] = inner ? 8'h00 : 8'hFF;
        1: lbp_mem[a] = inner ? 8'hA5 : 8'hFF;
        default: lbp_mem[a] = 8'(a);
      endcase
    end
  endtask

  task automatic model();
    for (int b = 0; b < 256; b++) expv[b] = 0;
    for (int r = 1; r <= 62; r++)
      for (int c = 1; c <= 62; c++)
        expv[lbp_mem[r * 64 + c]]++;
  endtask

  task automatic run(input bit hold, output int lat);
    lat = 0;
    enable = 1;
    for (int k = 0; k < 20000; k++) begin
      @(negedge clk);
      if (!hold) enable = 0;
      if (finish) break;
      if (busy) lat++;
    end
    enable = 0;
  endtask

  task automatic check_hist(input string tag);
    int bad, sum;
    bad = 0;
    sum = 0;
    model();
    for (int b = 0; b < 256; b++) begin
      sum += int'(hist_mem[b]);
      if (int'(hist_mem[b]) != expv[b]) begin
        bad++;
        if (bad <= 4)
          $display("FAIL %s bin %0d: got %0d, expected %0d",
                   tag, b, hist_mem[b], expv[b]);
      end
    end
    check({tag, " bins_wrong"}, bad, 0);
    check({tag, " sum"}, sum, NPIX);
  endtask

  initial begin
    int lat, bad8;
    vec[0] = '{0, 1'b1, 1'b0, 8'h00, NPIX, LAT};
    vec[1] = '{2, 1'b0, 1'b0, 8'h00, 0,    LAT};
    vec[2] = '{1, 1'b0, 1'b1, 8'hA5, NPIX, LAT};
    vec[3] = '{1, 1'b0, 1'b0, 8'hA5, NPIX, LAT};

    for (int a = 0; a < 4096; a++) begin
      lbp8_mem[a] = (a / 64 >= 1 && a / 64 <= 62 &&
                     a % 64 >= 1 && a % 64 <= 62) ? 8'h3C : 8'hFF;
    end

    #12;
    check("reset_outputs",
          int'({lbp_OE, hist_OE, hist_WEN, busy, finish,
                lbp_addr, hist_addr, hist_d}), 0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      string tag;
      tag = $sformatf("run%0d", i);
      fill(vec[i].pat);
      if (vec[i].preload) begin
        pre = 1;
        @(negedge clk);
        pre = 0;
        @(negedge clk);
      end
      use8 = (i == 0);
      run(vec[i].hold, lat);
      use8 = 0;
      check({tag, " latency"}, lat, vec[i].lat);
      check({tag, " finish"}, int'(finish), 1);
      check({tag, " spot"}, int'(hist_mem[vec[i].spot_bin]),
            vec[i].spot_val);
      check_hist(tag);
      if (i == 0) begin
        bad8 = 0;
        for (int b = 0; b < 256; b++)
          if (b != 8'h3C && hist8_mem[b] != 0) bad8++;
        check("sat8 bin3C", int'(hist8_mem[8'h3C]), 255);
        check("sat8 others", bad8, 0);
        check("sat8 finish", int'(finish8), 1);
      end
      if (i == 2) begin
        repeat (20) @(negedge clk);
        check("done_hold finish", int'(finish), 1);
        check("done_hold busy", int'(busy), 0);
      end
    end

    enable = 1;
    @(negedge clk);
    enable = 0;
    repeat (4999) @(negedge clk);
    check("midrun busy", int'(busy), 1);
    #2 rst = 0;
    #1;
    check("midrun reset_outputs",
          int'({lbp_OE, hist_OE, hist_WEN, busy, finish,
                lbp_addr, hist_addr, hist_d}), 0);
    @(negedge clk);
    check("midrun reset_held",
          int'({lbp_OE, hist_OE, hist_WEN, busy, finish}), 0);
    rst = 1;
    @(negedge clk);
    run(1'b0, lat);
    check("rerun latency", lat, LAT);
    check("rerun spot", int'(hist_mem[8'hA5]), NPIX);
    check_hist("rerun");

    check("strobe_exclusive", excl_err, 0);
    check("idle_outputs_zero", idle_err, 0);
    check("interior_reads_only", edge_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
